muldiv_seq: RTL and testbench

- Iterative sequencer for the RV32M multiply/divide extension, sitting beside the main ALU in the EX stage.
- Accepts one M-extension operation from the decoder (opcode OP_R_TYPE, funct7 0000001, funct3 selects the op) and computes it one bit per cycle.
- Holds the pipeline with a stall request until the result is ready, then returns the result with a one-cycle done pulse.

---
 rtl/muldiv_seq_pkg.sv | 35 +++
 rtl/muldiv_seq.sv | 146 ++++++++++++++
 tb/tb_muldiv_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq_pkg                                                       |
// | Shared RV32M encodings, sequencer states and operand-sign decode.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package muldiv_seq_pkg;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FUNCT3_MUL    = 3'b000;
  localparam logic [2:0] FUNCT3_MULH   = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
  localparam logic [2:0] FUNCT3_DIV    = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
  localparam logic [2:0] FUNCT3_REM    = 3'b110;
  localparam logic [2:0] FUNCT3_REMU   = 3'b111;

  localparam logic [1:0] MD_ST_IDLE = 2'd0;
  localparam logic [1:0] MD_ST_CALC = 2'd1;
  localparam logic [1:0] MD_ST_DONE = 2'd2;

  // MUL is deliberately absent: its low word does not depend on signedness.
  function automatic logic op_a_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_MULHSU) ||
           (f3 == FUNCT3_DIV)  || (f3 == FUNCT3_REM);
  endfunction

  function automatic logic op_b_signed(input logic [2:0] f3);
    return (f3 == FUNCT3_MULH) || (f3 == FUNCT3_DIV) || (f3 == FUNCT3_REM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | muldiv_seq                                                           |
// | One-bit-per-cycle RV32M multiply/divide sequencer with stall/done.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  c_int_min  = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_neg_q;
  logic              r_neg_r;
  logic [XLEN-1:0]   r_opnd;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_sa, w_sb;
  logic [XLEN-1:0]   w_abs_a, w_abs_b;
  logic              w_div0, w_ovf;
  logic [XLEN-1:0]   w_spec_res;
  logic [XLEN:0]     w_msum;
  logic [2*XLEN-1:0] w_mul_nxt;
  logic [XLEN:0]     w_rsh;
  logic [XLEN:0]     w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_div_nxt;
  logic [2*XLEN-1:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_quo, w_rem;
  logic [XLEN-1:0]   w_final;

  assign w_accept = (r_state == MD_ST_IDLE) & start & ~flush;
  assign w_sa     = op_a_signed(op) & a[XLEN-1];
  assign w_sb     = op_b_signed(op) & b[XLEN-1];
  assign w_abs_a  = w_sa ? -a : a;
  assign w_abs_b  = w_sb ? -b : b;
  assign w_div0   = op[2] & (b == '0);
  assign w_ovf    = op[2] & ~op[0] & (a == c_int_min) & (b == '1);

  always_comb begin
    w_spec_res = '0;
    if (w_div0)
      w_spec_res = op[1] ? a : '1;
    else if (w_ovf)
      w_spec_res = op[1] ? '0 : c_int_min;
  end

  // Multiply: acc = {partial product, remaining multiplier bits}, shifted right.
  assign w_msum    = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_nxt = {w_msum, r_acc[XLEN-1:1]};

  // Divide: acc = {partial remainder, dividend bits becoming quotient bits}, shifted left.
  assign w_rsh     = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rsh - {1'b0, r_opnd};
  assign w_ge      = ~w_diff[XLEN];
  assign w_div_nxt = {(w_ge ? w_diff[XLEN-1:0] : w_rsh[XLEN-1:0]), r_acc[XLEN-2:0], w_ge};
  assign w_acc_nxt = r_op[2] ? w_div_nxt : w_mul_nxt;

  always_comb begin
    w_prod  = r_neg_q ? -w_mul_nxt : w_mul_nxt;
    w_quo   = r_neg_q ? -w_div_nxt[XLEN-1:0] : w_div_nxt[XLEN-1:0];
    w_rem   = r_neg_r ? -w_div_nxt[2*XLEN-1:XLEN] : w_div_nxt[2*XLEN-1:XLEN];
    w_final = w_rem;
    case (r_op)
      FUNCT3_MUL:                             w_final = w_prod[XLEN-1:0];
      FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
      FUNCT3_DIV, FUNCT3_DIVU:                w_final = w_quo;
      default:                                w_final = w_rem;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= MD_ST_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_opnd   <= '0;
      r_acc    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        MD_ST_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
            r_cnt   <= '0;
            r_opnd  <= op[2] ? w_abs_b : w_abs_a;
            r_acc   <= {{XLEN{1'b0}}, (op[2] ? w_abs_a : w_abs_b)};
            if (w_div0 | w_ovf) begin
              r_result <= w_spec_res;
              r_state  <= MD_ST_DONE;
            end else begin
              r_state <= MD_ST_CALC;
            end
          end
        end
        MD_ST_CALC: begin
          if (flush) begin
            r_state <= MD_ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_acc <= w_acc_nxt;
            r_cnt <= (r_cnt == c_cnt_last) ? '0 : r_cnt + 1'b1;
            if (r_cnt == c_cnt_last) begin
              r_result <= w_final;
              r_state  <= MD_ST_DONE;
            end
          end
        end
        default: r_state <= MD_ST_IDLE;
      endcase
    end
  end

  assign stall  = w_accept | (r_state == MD_ST_CALC);
  assign busy   = (r_state != MD_ST_IDLE);
  assign done   = (r_state == MD_ST_DONE);
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_muldiv_seq                                                        |
// | Directed table, corner sequences and random ops vs arithmetic model. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'b000;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        flush = 1'b0;
  logic        stall, busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_fail = 0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .stall(stall), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on sign/zero-extended operands.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] sx, sy, ux, uy, p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    ux = {32'b0, x};
    uy = {32'b0, y};
    case (f)
      3'b000: begin p = ux * uy; return p[31:0]; end
      3'b001: begin p = sx * sy; return p[63:32]; end
      3'b010: begin p = sx * uy; return p[63:32]; end
      3'b011: begin p = ux * uy; return p[63:32]; end
      3'b100: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return $signed(x) / $signed(y);
      end
      3'b101: return (y == 0) ? 32'hFFFFFFFF : x / y;
      3'b110: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h0;
        return $signed(x) % $signed(y);
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
    if (f[2] && y == 0) return 1;
    if ((f == 3'b100 || f == 3'b110) && x == 32'h80000000 && y == 32'hFFFFFFFF) return 1;
    return 33;
  endfunction

  // Entered and left at #1 after a rising edge. Cycle 0 is the start cycle.
  task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y,
                        input int flush_at, input int poke_at,
                        output int lat, output int stalls);
    lat = -1;
    stalls = 0;
    op = f; a = x; b = y; start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (c == poke_at) begin
        start = 1'b1; op = 3'b111; a = $urandom; b = 32'd3;
      end
      if (c == flush_at) flush = 1'b1;
      #1;
      if (stall) stalls++;
      if (done && lat < 0) lat = c;
      @(posedge clk); #1;
      start = 1'b0;
      flush = 1'b0;
      if (c == flush_at || lat >= 0) return;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  vec_t vt[12];

  initial begin
    int lat, stalls;
    logic [31:0] last_exp;
    logic [2:0]  rf;
    logic [31:0] ra, rb;

    vt[0]  = '{3'b000, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 33};
    vt[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 33};
    vt[2]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33};
    vt[3]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33};
    vt[4]  = '{3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33};
    vt[5]  = '{3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33};
    vt[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       33};
    vt[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        33};
    vt[8]  = '{3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1};
    vt[9]  = '{3'b111, 32'd5,        32'd0,        32'd5,        1};
    vt[10] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
    vt[11] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1};

    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", {31'b0, stall}, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    chk("reset result", result, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    last_exp = 32'd0;
    for (int i = 0; i < 12; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, -1, -1, lat, stalls);
      chk($sformatf("vec%0d result", i), result, vt[i].exp);
      chk($sformatf("vec%0d done cycle", i), lat, vt[i].lat);
      chk($sformatf("vec%0d stall cycles", i), stalls, vt[i].lat);
      chk($sformatf("vec%0d busy after", i), {31'b0, busy}, 32'd0);
      chk($sformatf("vec%0d done pulse", i), {31'b0, done}, 32'd0);
      last_exp = vt[i].exp;
    end

    // Flush at CALC cycle 10, then an immediate new start.
    run_op(3'b011, 32'h12345678, 32'h9ABCDEF0, 10, -1, lat, stalls);
    chk("flush done seen", lat, -1);
    chk("flush busy", {31'b0, busy}, 32'd0);
    chk("flush done", {31'b0, done}, 32'd0);
    chk("flush result kept", result, last_exp);
    run_op(3'b101, 32'd100, 32'd7, -1, -1, lat, stalls);
    chk("post-flush result", result, 32'd14);
    chk("post-flush done cycle", lat, 33);

    // start pulsed mid-CALC must not disturb the running op.
    run_op(3'b000, 32'd7, 32'd6, -1, 5, lat, stalls);
    chk("poke result", result, 32'd42);
    chk("poke done cycle", lat, 33);
    chk("poke stall cycles", stalls, 33);

    // Async reset at CALC cycle 15.
    op = 3'b000; a = 32'd9; b = 32'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    chk("pre-reset busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid rst busy", {31'b0, busy}, 32'd0);
    chk("mid rst stall", {31'b0, stall}, 32'd0);
    chk("mid rst done", {31'b0, done}, 32'd0);
    chk("mid rst result", result, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_op(3'b000, 32'd3, 32'd4, -1, -1, lat, stalls);
    chk("after rst result", result, 32'd12);
    chk("after rst done cycle", lat, 33);

    for (int i = 0; i < 40; i++) begin
      rf = 3'($urandom_range(0, 7));
      ra = pick();
      rb = pick();
      run_op(rf, ra, rb, -1, -1, lat, stalls);
      chk($sformatf("rand%0d op%0d %h,%h result", i, rf, ra, rb), result, model(rf, ra, rb));
      chk($sformatf("rand%0d done cycle", i), lat, model_lat(rf, ra, rb));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
